// File: rtl/trail_particle_gen_pkg.sv
// Shared game constants and types so the renderer and the trail generator agree
// on geometry, slot count and gamemode encoding.
package trail_particle_gen_pkg;

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_PLAY  = 2'b01,
    GM_PAUSE = 2'b10,
    GM_OVER  = 2'b11
  } gamemode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_SPAWN = 2'b10
  } trail_state_e;

  localparam int GAME_N_TRAIL     = 41;
  localparam int GAME_PLAYER_X    = 160;
  localparam int GAME_PLAYER_SIZE = 40;
  localparam int GAME_LIFE_MAX    = 10;
  localparam int GAME_UPPER_BOUND = 20;
  localparam int GAME_LOWER_BOUND = 460;

  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int LIFE_W = 4;

  // Saturate a signed row coordinate into [lo, hi] before it is narrowed to 9 bits.
  function automatic logic [Y_W-1:0] clamp_y(input logic signed [10:0] v,
                                             input int lo, input int hi);
    logic signed [10:0] lo_s;
    logic signed [10:0] hi_s;
    logic signed [10:0] r;
    lo_s = 11'(lo);
    hi_s = 11'(hi);
    if (v < lo_s)      r = lo_s;
    else if (v > hi_s) r = hi_s;
    else               r = v;
    return r[Y_W-1:0];
  endfunction

endpackage

// File: rtl/trail_particle_gen_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); any non-zero seed keeps it
// off the all-zero lock-up state.
module trail_particle_gen_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/trail_particle_gen.sv
// Per-frame player trail: sweeps every slot (fade + leftward drift), then spawns
// one particle behind the player into a circular slot buffer.
module trail_particle_gen
  import trail_particle_gen_pkg::*;
#(
  parameter int N_TRAIL     = GAME_N_TRAIL,
  parameter int PLAYER_X    = GAME_PLAYER_X,
  parameter int PLAYER_SIZE = GAME_PLAYER_SIZE,
  parameter int LIFE_MAX    = GAME_LIFE_MAX,
  parameter int DRIFT       = 4,
  parameter int SPAWN_DIV   = 1,
  parameter int JITTER_EN   = 1,
  parameter int UPPER_BOUND = GAME_UPPER_BOUND,
  parameter int LOWER_BOUND = GAME_LOWER_BOUND
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic [1:0]                  gamemode,
  input  logic [8:0]                  player_y,
  output logic [N_TRAIL*X_W-1:0]      trail_x,
  output logic [N_TRAIL*Y_W-1:0]      trail_y,
  output logic [N_TRAIL*LIFE_W-1:0]   trail_life,
  output logic                        busy
);

  localparam int IDX_W = (N_TRAIL > 1) ? $clog2(N_TRAIL) : 1;
  localparam int CNT_W = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_TRAIL - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(SPAWN_DIV - 1);
  localparam logic [X_W-1:0]        DRIFT_X   = X_W'(DRIFT);
  localparam logic [X_W-1:0]        SPAWN_X   = X_W'(PLAYER_X);
  localparam logic [LIFE_W-1:0]     SPAWN_L   = LIFE_W'(LIFE_MAX);
  localparam logic signed [10:0]    Y_OFS     = 11'(PLAYER_SIZE / 2);

  trail_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;

  logic [X_W-1:0]    x_q    [N_TRAIL];
  logic [Y_W-1:0]    y_q    [N_TRAIL];
  logic [LIFE_W-1:0] life_q [N_TRAIL];

  logic clear;
  logic sweep_en;
  logic spawn_en;

  logic [7:0]         lfsr;
  logic               unused_lfsr_bits;
  logic signed [10:0] jitter;
  logic signed [10:0] y_sum;
  logic [Y_W-1:0]     spawn_y;

  trail_particle_gen_lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[7:3];

  always_comb begin
    jitter  = (JITTER_EN != 0) ? ($signed({8'b0, lfsr[2:0]}) - 11'sd4) : 11'sd0;
    y_sum   = $signed({2'b0, player_y}) + Y_OFS + jitter;
    spawn_y = clamp_y(y_sum, UPPER_BOUND + 2, LOWER_BOUND - 3);
  end

  // Gamemode INIT wipes the trail from any state and takes priority over a sweep.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    spawn_cnt_d = spawn_cnt_q;
    clear       = 1'b0;
    sweep_en    = 1'b0;
    spawn_en    = 1'b0;
    busy        = (state_q != ST_IDLE);
    if (gamemode == GM_INIT) begin
      clear       = 1'b1;
      state_d     = ST_IDLE;
      idx_d       = '0;
      wr_ptr_d    = '0;
      spawn_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_tick && gamemode == GM_PLAY) begin
            state_d = ST_SWEEP;
            idx_d   = '0;
          end
        end
        ST_SWEEP: begin
          sweep_en = 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_SPAWN;
          else                   idx_d   = idx_q + 1'b1;
        end
        ST_SPAWN: begin
          state_d = ST_IDLE;
          if (gamemode == GM_PLAY) begin
            if (spawn_cnt_q == LAST_CNT) begin
              spawn_en    = 1'b1;
              spawn_cnt_d = '0;
              wr_ptr_d    = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            end else begin
              spawn_cnt_d = spawn_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      spawn_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  // A particle dies when its life would reach zero or it would drift off the left edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TRAIL; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        life_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < N_TRAIL; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        life_q[i] <= '0;
      end
    end else begin
      if (sweep_en && life_q[idx_q] != '0) begin
        if (x_q[idx_q] < DRIFT_X || life_q[idx_q] == LIFE_W'(1)) begin
          life_q[idx_q] <= '0;
        end else begin
          life_q[idx_q] <= life_q[idx_q] - 1'b1;
          x_q[idx_q]    <= x_q[idx_q] - DRIFT_X;
        end
      end
      if (spawn_en) begin
        x_q[wr_ptr_q]    <= SPAWN_X;
        y_q[wr_ptr_q]    <= spawn_y;
        life_q[wr_ptr_q] <= SPAWN_L;
      end
    end
  end

  for (genvar g = 0; g < N_TRAIL; g++) begin : g_flat
    assign trail_x[g*X_W +: X_W]          = x_q[g];
    assign trail_y[g*Y_W +: Y_W]          = y_q[g];
    assign trail_life[g*LIFE_W +: LIFE_W] = life_q[g];
  end

endmodule

// File: tb/tb_trail_particle_gen.sv
// Directed bench for trail_particle_gen: one jitter-free instance checked against
// hand-computed slot contents, plus a jittered instance checked for range.
module tb_trail_particle_gen;

  localparam int N = 41;

  logic           clk;
  logic           rst_n;
  logic           frame_tick;
  logic [1:0]     gamemode;
  logic [8:0]     player_y;
  logic [N*10-1:0] tx, tx_j;
  logic [N*9-1:0]  ty, ty_j;
  logic [N*4-1:0]  tl, tl_j;
  logic            busy, busy_j;

  int n_cmp = 0;
  int n_bad = 0;

  trail_particle_gen #(.JITTER_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
    .player_y(player_y), .trail_x(tx), .trail_y(ty), .trail_life(tl), .busy(busy)
  );

  trail_particle_gen #(.JITTER_EN(1)) dut_j (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
    .player_y(player_y), .trail_x(tx_j), .trail_y(ty_j), .trail_life(tl_j), .busy(busy_j)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int i);
    return 32'(tx[i*10 +: 10]);
  endfunction
  function automatic logic [31:0] sy(input int i);
    return 32'(ty[i*9 +: 9]);
  endfunction
  function automatic logic [31:0] sl(input int i);
    return 32'(tl[i*4 +: 4]);
  endfunction
  function automatic logic [31:0] alive_cnt();
    logic [31:0] c = 0;
    for (int i = 0; i < N; i++) if (tl[i*4 +: 4] != 4'd0) c++;
    return c;
  endfunction
  function automatic logic [31:0] max_life();
    logic [31:0] m = 0;
    for (int i = 0; i < N; i++) if (32'(tl[i*4 +: 4]) > m) m = 32'(tl[i*4 +: 4]);
    return m;
  endfunction

  // Pulses frame_tick, optionally re-pulses it retick_at cycles into the busy window,
  // and returns how many sampled cycles busy stayed high (bounded at 100).
  task automatic run_frame(input int retick_at, output int nbusy);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      frame_tick = (retick_at != 0 && nbusy == retick_at);
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
  endtask

  logic [N*10-1:0] snap_x;
  logic [N*9-1:0]  snap_y;
  logic [N*4-1:0]  snap_l;
  int nb;
  int bad_busy;
  logic busy_seen;
  logic [31:0] yj;

  initial begin
    rst_n      = 1'b1;
    frame_tick = 1'b0;
    gamemode   = 2'b01;
    player_y   = 9'd200;
    #2 rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_alive", alive_cnt(), 0);
    check("reset_x0", sx(0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First frame: 42 busy cycles, slot 0 spawned.
    run_frame(0, nb);
    check("busy_len_f1", nb, 42);
    check("f1_x0", sx(0), 160);
    check("f1_y0", sy(0), 220);
    check("f1_l0", sl(0), 10);
    check("f1_alive", alive_cnt(), 1);
    yj = 32'(ty_j[0 +: 9]);
    check("jit_y0_range", 32'(yj >= 216 && yj <= 223), 1);
    check("jit_l0", 32'(tl_j[0 +: 4]), 10);

    // Frames 2..4; frame 4 carries a second tick at sweep cycle 10.
    run_frame(0, nb);
    run_frame(0, nb);
    run_frame(10, nb);
    check("busy_len_retick", nb, 42);
    check("f4_x0", sx(0), 148);
    check("f4_l0", sl(0), 7);
    check("f4_y0", sy(0), 220);
    check("f4_x1", sx(1), 152);
    check("f4_l1", sl(1), 8);
    check("f4_x3", sx(3), 160);
    check("f4_y3", sy(3), 220);
    check("f4_l3", sl(3), 10);
    check("f4_alive", alive_cnt(), 4);

    // Frames 5..41 fill every slot once.
    bad_busy = 0;
    for (int f = 5; f <= 41; f++) begin
      run_frame(0, nb);
      if (nb != 42) bad_busy++;
    end
    check("busy_len_loop", bad_busy, 0);
    check("f41_l40", sl(40), 10);
    check("f41_x40", sx(40), 160);
    check("f41_l0_dead", sl(0), 0);
    check("f41_alive", alive_cnt(), 10);

    // Frame 42 wraps the write pointer back to slot 0.
    run_frame(0, nb);
    check("f42_l0", sl(0), 10);
    check("f42_x0", sx(0), 160);
    check("f42_l40", sl(40), 9);

    run_frame(0, nb);
    run_frame(0, nb);
    run_frame(0, nb);
    check("f45_l3", sl(3), 10);
    check("f45_l0", sl(0), 7);
    check("f45_x0", sx(0), 148);
    check("f45_l35", sl(35), 1);
    check("f45_x35", sx(35), 124);
    check("f45_l34", sl(34), 0);
    check("f45_alive", alive_cnt(), 10);
    check("f45_maxlife", max_life(), 10);

    // Clamp at the playfield borders.
    player_y = 9'd0;
    run_frame(0, nb);
    check("clamp_top_y4", sy(4), 22);
    check("clamp_top_l4", sl(4), 10);
    yj = 32'(ty_j[4*9 +: 9]);
    check("jit_top_range", 32'(yj == 22 || yj == 23), 1);
    player_y = 9'd440;
    run_frame(0, nb);
    check("clamp_bot_y5", sy(5), 457);
    yj = 32'(ty_j[5*9 +: 9]);
    check("jit_bot_range", 32'(yj == 456 || yj == 457), 1);

    // Paused: frame_tick ignored, trail frozen.
    gamemode = 2'b10;
    snap_x = tx;
    snap_y = ty;
    snap_l = tl;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      busy_seen = busy_seen | busy;
      @(posedge clk); #1;
    end
    check("pause_busy", 32'(busy_seen), 0);
    check("pause_x", 32'(tx === snap_x), 1);
    check("pause_y", 32'(ty === snap_y), 1);
    check("pause_l", 32'(tl === snap_l), 1);

    // INIT mode mid-sweep wipes everything on the next edge.
    gamemode = 2'b01;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("pre_init_busy", 32'(busy), 1);
    gamemode = 2'b00;
    @(posedge clk); #1;
    check("init_alive", alive_cnt(), 0);
    check("init_busy", 32'(busy), 0);
    check("init_x5", sx(5), 0);
    check("init_y5", sy(5), 0);
    gamemode = 2'b01;
    player_y = 9'd100;
    @(posedge clk); #1;
    run_frame(0, nb);
    check("post_init_len", nb, 42);
    check("post_init_l0", sl(0), 10);
    check("post_init_y0", sy(0), 120);
    check("post_init_alive", alive_cnt(), 1);

    // Asynchronous reset mid-sweep.
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst_alive", alive_cnt(), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_x0", sx(0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, nb);
    check("post_rst_len", nb, 42);
    check("post_rst_l0", sl(0), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trail_particle_gen.md
Name: trail_particle_gen

Overview:
- Produces the player trail particle arrays consumed by the VGA pixel/colour stage: per-particle centre x, centre y and remaining life (0 = dead, LIFE_MAX = brightest).
- Once per video frame: sweeps all particles (fade + leftward drift), then spawns one new particle behind the player into a circular slot buffer.
- Runs in the clk domain next to the game FSM; frame_tick comes from the VGA timing generator at start of vertical blanking.

Parameters:
- N_TRAIL, 41, number of particle slots (index width clog2).
- PLAYER_X, 160, spawn x (player left edge).
- PLAYER_SIZE, 40, player sprite height; spawn y centre offset = PLAYER_SIZE/2.
- LIFE_MAX, 10, life loaded at spawn.
- DRIFT, 4, pixels subtracted from x per frame.
- SPAWN_DIV, 1, spawn one particle every SPAWN_DIV frames (>=1).
- JITTER_EN, 1, 1 = add LFSR y jitter of -4..+3.
- UPPER_BOUND, 20, playfield top border row.
- LOWER_BOUND, 460, playfield bottom border row.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse per frame, issued during blanking.
- gamemode  input  2  00 initial, 01 in-game, 10 paused, 11 game over.
- player_y  input  9  player sprite top row.
- trail_x  output  N_TRAIL x 10  particle centre x.
- trail_y  output  N_TRAIL x 9  particle centre y.
- trail_life  output  N_TRAIL x 4  particle life; 0 = not drawn.
- busy  output  1  high while a sweep/spawn is in progress.

Behaviour:
- Reset (async assert, sync release): all trail_x/trail_y/trail_life = 0; busy = 0; wr_ptr = 0; spawn_cnt = 0; idx = 0; LFSR = 8'hA5; state IDLE.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle out of reset; never zero.
- States: IDLE, SWEEP, SPAWN.
- IDLE: on frame_tick with gamemode == 01 -> SWEEP, idx = 0, busy = 1 next cycle. frame_tick in modes 10/11 ignored (trail frozen, still displayed).
- SWEEP: one slot per cycle, idx 0..N_TRAIL-1. For slot idx with life > 0: life <= life-1; x <= x-DRIFT. If x < DRIFT, or new life == 0, life <= 0 (x/y values then don't care). Dead slots untouched. After idx == N_TRAIL-1 -> SPAWN.
- SPAWN (1 cycle): if gamemode == 01 and spawn_cnt == SPAWN_DIV-1, write slot wr_ptr: x = PLAYER_X, y = clamp(player_y + PLAYER_SIZE/2 + jitter, UPPER_BOUND+2, LOWER_BOUND-3), life = LIFE_MAX; wr_ptr increments, wrapping N_TRAIL-1 -> 0 (oldest slot overwritten regardless of life); spawn_cnt = 0. Otherwise spawn_cnt increments (only in mode 01). -> IDLE, busy = 0.
- jitter = JITTER_EN ? signed(lfsr[2:0]) - 4 : 0; arithmetic in 11-bit signed, clamp before truncation to 9 bits.
- Latency: frame_tick at cycle T -> busy high T+1..T+N_TRAIL+1; spawned slot visible at T+N_TRAIL+2. Total 42 cycles at defaults; must complete inside vertical blanking.
- frame_tick while busy: ignored (no queueing).
- Mode change to 10/11 mid-sweep: sweep completes; spawn suppressed.
- gamemode == 00 in any state: next cycle all life = 0, x = y = 0, wr_ptr = 0, spawn_cnt = 0, state IDLE, busy = 0. Overrides sweep.
- Reset mid-sweep: immediate return to reset values.

Decomposition:
- Shared game package: gamemode enum (INIT/PLAY/PAUSE/OVER), PLAYER_X, PLAYER_SIZE, UPPER_BOUND, LOWER_BOUND, N_TRAIL, LIFE_MAX, so the renderer and this block agree.
- One sub-module: lfsr8 (clk, rst_n, seed param, 8-bit out).
- Sweep FSM and slot arrays stay in trail_particle_gen.

Test Plan:
- Reset release, gamemode 01, player_y = 200, JITTER_EN = 0, one frame_tick -> busy high 42 cycles; slot 0 = (160, 220, 10); all other lives 0.
- Three more frame_ticks -> slot 0 = (148, 220, 7); slot 3 = (160, 220, 10); wr_ptr = 4.
- 45 frames, player_y fixed -> wr_ptr wraps 40 -> 0; slot 0 overwritten with life 10; no life exceeds 10; lives die at 0 after 10 frames.
- player_y = 0 with jitter -> spawned y = 22; player_y = 440 -> y = 457.
- gamemode 10, frame_tick -> arrays unchanged, busy stays 0. Then gamemode 00 pulsed mid-sweep -> all lives 0 next cycle, busy 0.
- frame_tick repeated at sweep cycle 10 -> ignored; exactly one decrement per slot. Reset asserted mid-sweep -> outputs 0 immediately.
